// File: rtl/memory_requester.sv
// memory_requester
//   Initiator for a memory_bank. It takes one line-sized read or write request
//   at a time over a valid/ready handshake. It holds address and data on the
//   bank for MEMORY_LATENCY cycles and pulses the bank write strobe in the last
//   of those cycles for writes. It then returns a one-cycle response that
//   carries the line read, or the written data for writes.
//
// Ports
//   clk, reset        : single rising-edge clock, synchronous active-high reset
//   req_valid/ready   : request handshake; ready only in IDLE and not in reset
//   req_write         : 1 = write line, 0 = read line
//   req_addr/req_data : line address and write data (data ignored for reads)
//   resp_valid        : one-cycle completion pulse
//   resp_write        : echo of the completed request's req_write
//   resp_data         : line read, or the written data for writes
//   mem_addr/data_in  : held toward the bank while the request is in flight
//   mem_write         : bank write strobe, last busy cycle of a write only
//   mem_data_out      : combinational read data from the bank at mem_addr
module memory_requester #(
  parameter int MEMORY_LINE_LENGTH  = 256,
  parameter int MEMORY_ADDRESS_SIZE = 2,
  parameter int MEMORY_LATENCY      = 5
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           req_valid,
  output logic                           req_ready,
  input  logic                           req_write,
  input  logic [0:MEMORY_ADDRESS_SIZE-1] req_addr,
  input  logic [0:MEMORY_LINE_LENGTH-1]  req_data,
  output logic                           resp_valid,
  output logic                           resp_write,
  output logic [0:MEMORY_LINE_LENGTH-1]  resp_data,
  output logic [0:MEMORY_ADDRESS_SIZE-1] mem_addr,
  output logic [0:MEMORY_LINE_LENGTH-1]  mem_data_in,
  output logic                           mem_write,
  input  logic [0:MEMORY_LINE_LENGTH-1]  mem_data_out
);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  // Counter reload value: BUSY lasts MEMORY_LATENCY cycles, counting down to 0.
  localparam logic [7:0] CNT_LOAD = 8'(MEMORY_LATENCY - 1);

  state_t                           state_q, state_d;
  logic [7:0]                       cnt_q, cnt_d;
  logic                             wr_q, wr_d;
  logic [0:MEMORY_ADDRESS_SIZE-1]   addr_q, addr_d;
  logic [0:MEMORY_LINE_LENGTH-1]    data_q, data_d;
  logic                             mem_write_q, mem_write_d;
  logic                             resp_valid_q, resp_valid_d;
  logic                             resp_write_q, resp_write_d;
  logic [0:MEMORY_LINE_LENGTH-1]    resp_data_q, resp_data_d;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    wr_d         = wr_q;
    addr_d       = addr_q;
    data_d       = data_q;
    resp_write_d = resp_write_q;
    resp_data_d  = resp_data_q;
    resp_valid_d = 1'b0;
    mem_write_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          state_d = BUSY;
          cnt_d   = CNT_LOAD;
          wr_d    = req_write;
          addr_d  = req_addr;
          data_d  = req_data;
          // With a one-cycle latency the first BUSY cycle is also the last.
          mem_write_d = req_write && (CNT_LOAD == 8'd0);
        end
      end
      BUSY: begin
        if (cnt_q == 8'd0) begin
          // Closing edge of the last BUSY cycle: bank commits / read captured.
          state_d      = RESP;
          resp_valid_d = 1'b1;
          resp_write_d = wr_q;
          resp_data_d  = wr_q ? data_q : mem_data_out;
        end else begin
          cnt_d = cnt_q - 8'd1;
          // Strobe is registered, so raise it when entering the counter==0 cycle.
          mem_write_d = wr_q && (cnt_q == 8'd1);
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      cnt_q        <= 8'd0;
      wr_q         <= 1'b0;
      addr_q       <= '0;
      data_q       <= '0;
      mem_write_q  <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_write_q <= 1'b0;
      resp_data_q  <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      wr_q         <= wr_d;
      addr_q       <= addr_d;
      data_q       <= data_d;
      mem_write_q  <= mem_write_d;
      resp_valid_q <= resp_valid_d;
      resp_write_q <= resp_write_d;
      resp_data_q  <= resp_data_d;
    end
  end

  // Reset gates ready and the write strobe directly so that a write whose
  // commit edge coincides with reset never reaches the bank.
  assign req_ready   = (state_q == IDLE) && !reset;
  assign mem_write   = mem_write_q && !reset;
  assign mem_addr    = addr_q;
  assign mem_data_in = data_q;
  assign resp_valid  = resp_valid_q;
  assign resp_write  = resp_write_q;
  assign resp_data   = resp_data_q;

endmodule

// File: tb/tb_memory_requester.sv
// Testbench for memory_requester: a latency-5 and a latency-1 instance, each
// with its own behavioural bank. Accepted requests push expected responses
// into a per-instance queue; monitors pop and compare on resp_valid.
module tb_memory_requester;
  localparam int LW = 256;
  localparam int AW = 2;
  typedef logic [0:LW-1] line_t;
  typedef struct { logic w; line_t data; int due; } exp_t;
  typedef struct { logic w; logic [0:AW-1] a; line_t d; line_t exp; } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset, bank_init;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  // latency-5 instance
  logic v5, w5, rdy5, rv5, rw5, mw5;
  logic [0:AW-1] a5, ma5;
  line_t d5, rd5, mdi5, mdo5;
  // latency-1 instance
  logic v1, w1, rdy1, rv1, rw1, mw1;
  logic [0:AW-1] a1, ma1;
  line_t d1, rd1, mdi1, mdo1;

  memory_requester #(.MEMORY_LINE_LENGTH(LW), .MEMORY_ADDRESS_SIZE(AW), .MEMORY_LATENCY(5)) u5 (
    .clk(clk), .reset(reset), .req_valid(v5), .req_ready(rdy5), .req_write(w5),
    .req_addr(a5), .req_data(d5), .resp_valid(rv5), .resp_write(rw5), .resp_data(rd5),
    .mem_addr(ma5), .mem_data_in(mdi5), .mem_write(mw5), .mem_data_out(mdo5));

  memory_requester #(.MEMORY_LINE_LENGTH(LW), .MEMORY_ADDRESS_SIZE(AW), .MEMORY_LATENCY(1)) u1 (
    .clk(clk), .reset(reset), .req_valid(v1), .req_ready(rdy1), .req_write(w1),
    .req_addr(a1), .req_data(d1), .resp_valid(rv1), .resp_write(rw1), .resp_data(rd1),
    .mem_addr(ma1), .mem_data_in(mdi1), .mem_write(mw1), .mem_data_out(mdo1));

  // Behavioural banks: combinational read, commit on the rising edge.
  line_t bank5 [4];
  line_t bank1 [4];
  assign mdo5 = bank5[ma5];
  assign mdo1 = bank1[ma1];
  always @(posedge clk) begin
    if (bank_init) begin
      bank5[0] <= {32{8'h11}}; bank5[1] <= {32{8'hAA}};
      bank5[2] <= {32{8'h33}}; bank5[3] <= '0;
      bank1[0] <= '0; bank1[1] <= {32{8'h0F}}; bank1[2] <= '0; bank1[3] <= '0;
    end else begin
      if (mw5) bank5[ma5] <= mdi5;
      if (mw1) bank1[ma1] <= mdi1;
    end
  end

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", name, act, exp);
    end
  endtask

  // Scoreboards and strobe monitors.
  exp_t q5[$];
  exp_t q1[$];
  exp_t e5, e1;
  int mwc5 = 0, last_mw5 = -1, mwc1 = 0, last_mw1 = -1;

  always @(negedge clk) begin
    if (mw5) begin mwc5++; last_mw5 = cyc; end
    if (rv5) begin
      if (q5.size() == 0) chk("resp5_spurious", {255'd0, rv5}, 256'd0);
      else begin
        e5 = q5.pop_front();
        chk("resp5_data", rd5, e5.data);
        chk("resp5_write", {255'd0, rw5}, {255'd0, e5.w});
        chk("resp5_cycle", cyc, e5.due);
      end
    end else if (q5.size() != 0 && cyc > q5[0].due) begin
      e5 = q5.pop_front();
      chk("resp5_missing", {255'd0, rv5}, 256'd1);
    end
  end

  always @(negedge clk) begin
    if (mw1) begin mwc1++; last_mw1 = cyc; end
    if (rv1) begin
      if (q1.size() == 0) chk("resp1_spurious", {255'd0, rv1}, 256'd0);
      else begin
        e1 = q1.pop_front();
        chk("resp1_data", rd1, e1.data);
        chk("resp1_write", {255'd0, rw1}, {255'd0, e1.w});
        chk("resp1_cycle", cyc, e1.due);
      end
    end else if (q1.size() != 0 && cyc > q1[0].due) begin
      e1 = q1.pop_front();
      chk("resp1_missing", {255'd0, rv1}, 256'd1);
    end
  end

  // Present a request at a falling edge and wait for acceptance. Returns one
  // falling edge after the accepting rising edge; acc is the cycle count then.
  task automatic issue(input int sel, input logic w, input logic [0:AW-1] a,
                       input line_t d, input line_t exp, input logic hold, output int acc);
    int n = 0;
    int lat = (sel == 0) ? 5 : 1;
    exp_t e;
    if (sel == 0) begin w5 = w; a5 = a; d5 = d; v5 = 1'b1; end
    else          begin w1 = w; a1 = a; d1 = d; v1 = 1'b1; end
    while ((((sel == 0) ? rdy5 : rdy1) !== 1'b1) && n < 40) begin
      @(negedge clk);
      n++;
    end
    acc = cyc + 1;
    if (n >= 40) chk("accept_timeout", n, 256'd0);
    else begin
      e.w = w; e.data = exp; e.due = cyc + 1 + lat;
      if (sel == 0) q5.push_back(e); else q1.push_back(e);
    end
    @(negedge clk);
    if (!hold) begin
      if (sel == 0) v5 = 1'b0; else v1 = 1'b0;
    end
  endtask

  task automatic drain();
    int n = 0;
    while ((q5.size() + q1.size()) != 0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("drain", q5.size() + q1.size(), 256'd0);
    q5.delete();
    q1.delete();
    @(negedge clk);
  endtask

  vec_t vecs [6];
  int acc, acc2, m0;

  initial begin
    vecs[0] = '{1'b1, 2'd0, {32{8'h5A}}, {32{8'h5A}}};
    vecs[1] = '{1'b0, 2'd0, '0,          {32{8'h5A}}};
    vecs[2] = '{1'b0, 2'd2, '0,          {32{8'h33}}};
    vecs[3] = '{1'b1, 2'd1, {16{16'h0123}}, {16{16'h0123}}};
    vecs[4] = '{1'b0, 2'd1, {32{8'hFF}}, {16{16'h0123}}};
    vecs[5] = '{1'b0, 2'd3, '0,          256'd4 - 256'd4};

    reset = 1'b1; bank_init = 1'b1;
    v5 = 0; w5 = 0; a5 = '0; d5 = '0;
    v1 = 0; w1 = 0; a1 = '0; d1 = '0;
    repeat (3) @(negedge clk);
    bank_init = 1'b0;

    // reset state
    chk("rst_ready", {255'd0, rdy5}, 256'd0);
    chk("rst_resp_valid", {255'd0, rv5}, 256'd0);
    chk("rst_resp_write", {255'd0, rw5}, 256'd0);
    chk("rst_resp_data", rd5, 256'd0);
    chk("rst_mem_addr", ma5, 256'd0);
    chk("rst_mem_data_in", mdi5, 256'd0);
    chk("rst_mem_write", {255'd0, mw5}, 256'd0);
    chk("rst_ready1", {255'd0, rdy1}, 256'd0);
    reset = 1'b0;
    @(negedge clk);
    chk("ready_after_reset", {255'd0, rdy5}, 256'd1);
    chk("ready_after_reset1", {255'd0, rdy1}, 256'd1);

    // read line 1 with latency 5: address held, no strobe, ready low
    issue(0, 1'b0, 2'd1, '0, {32{8'hAA}}, 1'b0, acc);
    for (int k = 0; k < 5; k++) begin
      chk("rd_busy_addr", ma5, 256'd1);
      chk("rd_busy_write", {255'd0, mw5}, 256'd0);
      chk("rd_busy_ready", {255'd0, rdy5}, 256'd0);
      chk("rd_busy_resp", {255'd0, rv5}, 256'd0);
      @(negedge clk);
    end
    drain();

    // write top address, then read it back
    m0 = mwc5;
    issue(0, 1'b1, 2'd3, 256'd4, 256'd4, 1'b0, acc);
    drain();
    chk("wr_strobe_count", mwc5 - m0, 256'd1);
    chk("wr_strobe_cycle", last_mw5, acc + 4);
    chk("wr_bank3", bank5[3], 256'd4);
    issue(0, 1'b0, 2'd3, '0, 256'd4, 1'b0, acc);
    drain();

    // table of mixed requests
    vecs[5].exp = 256'd4;
    for (int i = 0; i < 6; i++) begin
      issue(0, vecs[i].w, vecs[i].a, vecs[i].d, vecs[i].exp, 1'b0, acc);
      drain();
    end

    // back-to-back with req_valid held high
    issue(0, 1'b0, 2'd0, '0, {32{8'h5A}}, 1'b1, acc);
    issue(0, 1'b0, 2'd2, '0, {32{8'h33}}, 1'b0, acc2);
    chk("b2b_gap", acc2 - acc, 256'd7);
    drain();

    // request during BUSY is ignored
    issue(0, 1'b0, 2'd1, '0, {16{16'h0123}}, 1'b0, acc);
    @(negedge clk);
    v5 = 1'b1; w5 = 1'b1; a5 = 2'd0; d5 = {32{8'hEE}};
    @(negedge clk);
    v5 = 1'b0; w5 = 1'b0;
    drain();
    chk("busy_ignore_bank0", bank5[0], {32{8'h5A}});

    // reset during the strobe cycle of a write
    issue(0, 1'b1, 2'd2, {32{8'h55}}, {32{8'h55}}, 1'b0, acc);
    repeat (4) @(negedge clk);
    reset = 1'b1;
    q5.delete();
    #1;
    chk("rstw_mem_write", {255'd0, mw5}, 256'd0);
    @(negedge clk);
    chk("rstw_bank2", bank5[2], {32{8'h33}});
    chk("rstw_resp_valid", {255'd0, rv5}, 256'd0);
    chk("rstw_resp_data", rd5, 256'd0);
    chk("rstw_mem_addr", ma5, 256'd0);
    chk("rstw_mem_data_in", mdi5, 256'd0);
    chk("rstw_ready", {255'd0, rdy5}, 256'd0);
    reset = 1'b0;
    @(negedge clk);
    chk("rstw_ready_after", {255'd0, rdy5}, 256'd1);
    chk("rstw_no_resp", {255'd0, rv5}, 256'd0);

    // latency-1 instance: write then read line 1
    m0 = mwc1;
    issue(1, 1'b1, 2'd1, {32{8'hC3}}, {32{8'hC3}}, 1'b0, acc);
    drain();
    chk("l1_strobe_count", mwc1 - m0, 256'd1);
    chk("l1_strobe_cycle", last_mw1, acc);
    issue(1, 1'b0, 2'd1, '0, {32{8'hC3}}, 1'b0, acc);
    drain();
    chk("l1_read_no_strobe", mwc1 - m0, 256'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got %0d want finished", cyc);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/memory_requester.md
# memory_requester

Initiator that drives a `memory_bank` on behalf of the cache/fetch logic. It accepts one line-sized read or write request at a time over a valid/ready handshake. It presents address and data to the bank for a fixed, parameterised access latency, and pulses the bank write strobe once for writes. It returns the line (reads) or an acknowledge (writes) as a one-cycle response.

## Interface

Parameters:
- `MEMORY_LINE_LENGTH`, 256, bits per memory line; matches the bank.
- `MEMORY_ADDRESS_SIZE`, 2, address width in lines; matches the bank.
- `MEMORY_LATENCY`, 5, cycles a request occupies the bank; legal range 1..255.

Ports (vectors are `[0:N-1]`, bit 0 = MSB):
- `clk` in 1: single clock, all state on rising edge.
- `reset` in 1: synchronous, active-high.
- `req_valid` in 1: request present.
- `req_ready` out 1: block can accept a request; equals (state==IDLE && !reset).
- `req_write` in 1: 1 = write line, 0 = read line.
- `req_addr` in `MEMORY_ADDRESS_SIZE`: line address.
- `req_data` in `MEMORY_LINE_LENGTH`: write data; ignored for reads.
- `resp_valid` out 1: one-cycle response pulse.
- `resp_write` out 1: echoes `req_write` of the completed request.
- `resp_data` out `MEMORY_LINE_LENGTH`: line read from the bank; for writes, holds the written data.
- `mem_addr` out `MEMORY_ADDRESS_SIZE`: to bank `addr`.
- `mem_data_in` out `MEMORY_LINE_LENGTH`: to bank `data_in`.
- `mem_write` out 1: to bank `write`.
- `mem_data_out` in `MEMORY_LINE_LENGTH`: from bank `data_out`; combinational read of `mem_addr`.

## Operation

- The FSM has three states.
  - IDLE -> BUSY on `req_valid && req_ready`.
  - BUSY -> RESP when the counter reaches 0.
  - RESP -> IDLE unconditionally.
- Acceptance:
  - Latch `req_write`, `req_addr`, and `req_data` into `mem_addr` and `mem_data_in`, plus an internal write flag.
  - Load the counter with `MEMORY_LATENCY-1`.
- BUSY:
  - `mem_addr` and `mem_data_in` are held constant.
  - The counter decrements each cycle; its width is 8 bits and it never wraps below 0.
- Last BUSY cycle (counter==0):
  - Writes: `mem_write`=1 for exactly this cycle. The bank commits on the closing edge.
  - Reads: `mem_data_out` is captured into `resp_data` on the closing edge.
  - Writes copy `mem_data_in` into `resp_data`.
- RESP: `resp_valid`=1 for one cycle. `resp_data` and `resp_write` stay stable until the next response.
- `req_valid` outside IDLE is ignored. Nothing is queued, and the requester must hold its request.
- Addresses are used unmodified. `MEMORY_ADDRESS_SIZE` fixes the range, so address 2^N-1 is legal and no wrap logic exists.
- `mem_write` is never asserted outside the last BUSY cycle of a write.

## Timing

- Reset values of all outputs are 0: `req_ready`, `resp_valid`, `resp_write`, `resp_data`, `mem_addr`, `mem_data_in`, `mem_write`. The state is IDLE.
- `req_ready` reads 1 from the first cycle after reset deasserts.
- If acceptance happens at edge E0:
  - BUSY occupies cycles E0+1 .. E0+`MEMORY_LATENCY`.
  - `resp_valid` is high in cycle E0+`MEMORY_LATENCY`+1.
  - `req_ready` is high again in cycle E0+`MEMORY_LATENCY`+2.
- Throughput is one request per `MEMORY_LATENCY`+2 cycles.
- With `MEMORY_LATENCY`=1, BUSY lasts one cycle and `mem_write` pulses in that cycle.
- `reset` asserted during BUSY or RESP:
  - Return to IDLE and clear all outputs on that edge.
  - An in-flight write whose `mem_write` cycle coincides with the reset edge is dropped, because `mem_write` is forced to 0.
  - No response is generated.
- A `reset` edge coinciding with `req_valid` takes priority, and the request is not accepted.

## Test plan

- Read, latency 5: preload bank line 1 = 0xAA..AA. Accept read at E0 -> `mem_addr`=1 for 5 cycles, `mem_write`=0 throughout, `resp_valid` only at E0+6 with `resp_data`=0xAA..AA and `resp_write`=0.
- Write then read back: write addr 3 (top address) data 4 -> `mem_write` high only in cycle E0+5. Then read addr 3 -> `resp_data`=4.
- Back-to-back: hold `req_valid` continuously for read 0 and then read 2 -> second acceptance exactly 7 cycles after the first, `req_ready`=0 in between, and two `resp_valid` pulses 7 cycles apart.
- Busy ignore: pulse `req_valid` with write addr 0 during BUSY of a read -> no acceptance, and bank line 0 is unchanged.
- Reset mid-write: assert `reset` at edge E0+5 of a write of 0x55 to addr 2 -> `mem_write`=0, line 2 keeps its old value, no `resp_valid`, all outputs 0, and `req_ready`=1 one cycle after `reset` drops.
- Latency 1 build: a write followed by a read of addr 1 -> `resp_valid` at E0+2 for each request, and `mem_write` high for exactly one cycle.
